// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Imported by the interface, the top and the bench.
package sub_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result valid-ready bundle for serial_subtractor.
// master = producer/consumer side, slave = the subtractor.
interface serial_subtractor_if
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  diff,
    input  borrow
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output diff,
    output borrow
  );

endinterface

// File: rtl/full_subtractor.sv
// 1-bit full subtractor built from two half subtractors.
// d = x - y - bin (mod 2), bout set when the result went negative.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bout
);

  assign d    = x ^ y;
  assign bout = ~x & y;

endmodule

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs0 (
    .x    (x),
    .y    (y),
    .d    (d1),
    .bout (b1)
  );

  half_subtractor u_hs1 (
    .x    (d1),
    .y    (bin),
    .d    (d),
    .bout (b2)
  );

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: LSB-first, one bit per clock,
// one full_subtractor cell, valid/ready on both sides.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] sh_d_nx;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bout;
  logic             take;
  logic             give;
  logic             last;

  full_subtractor u_fs (
    .x    (sh_a[0]),
    .y    (sh_b[0]),
    .bin  (brw),
    .d    (d),
    .bout (bout)
  );

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;

  assign take    = bus.in_valid && bus.in_ready;
  assign give    = bus.out_valid && bus.out_ready;
  assign last    = (cnt == LAST);
  assign sh_d_nx = {d, sh_d[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (take) state_nx = S_RUN;
      S_RUN:  if (last) state_nx = S_DONE;
      S_DONE: if (give) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Result registers only load on the final bit, so they hold
  // the previous answer through IDLE and RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a     <= '0;
      sh_b     <= '0;
      sh_d     <= '0;
      brw      <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (take) begin
      sh_a <= bus.a;
      sh_b <= bus.b;
      sh_d <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (state == S_RUN) begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
      sh_d <= sh_d_nx;
      brw  <= bout;
      cnt  <= last ? '0 : cnt + CW'(1);
      if (last) begin
        diff_q   <= sh_d_nx;
        borrow_q <= bout;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + randomised self-checking bench for serial_subtractor
// and an exhaustive truth-table check of full_subtractor.
module tb_serial_subtractor;
  import sub_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  logic fx, fy, fbin, fd, fbout;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  full_subtractor u_fs (
    .x    (fx),
    .y    (fy),
    .bin  (fbin),
    .d    (fd),
    .bout (fbout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one operand pair from IDLE with out_ready high.
  task automatic run_op(input logic [7:0] ra,
                        input logic [7:0] rb,
                        input logic [7:0] ed,
                        input logic       eb);
    int   lat;
    logic busy_ok;
    bus.a         = ra;
    bus.b         = rb;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    check("in_ready_idle", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 20) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bus.in_ready) busy_ok = 1'b0;
    check("latency", lat, 9);
    check("in_ready_busy_low", busy_ok, 1);
    check("diff", bus.diff, ed);
    check("borrow", bus.borrow, eb);
    @(negedge clk);
    check("in_ready_after", bus.in_ready, 1);
    check("out_valid_after", bus.out_valid, 0);
  endtask

  initial begin
    logic [2:0] v;
    int         r;
    logic [7:0] ra, rb;
    int         n_acc, n_hs, wt;
    logic       got_hs;

    n_chk  = 0;
    n_fail = 0;

    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      {fx, fy, fbin} = v;
      #1;
      r = int'(fx) - int'(fy) - int'(fbin);
      check("fs_d", fd, (r & 1));
      check("fs_bout", fbout, (r < 0) ? 1 : 0);
    end

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_diff", bus.diff, 0);
    check("rst_borrow", bus.borrow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h05, 8'h03, 8'h02, 1'b0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0);
    run_op(8'hFF, 8'h00, 8'hFF, 1'b0);

    // Backpressure, with junk operands held valid while busy.
    bus.out_ready = 1'b0;
    bus.a         = 8'h80;
    bus.b         = 8'h01;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.a = 8'h11;
    bus.b = 8'h00;
    wt = 0;
    while (!bus.out_valid && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    check("bp_reached_done", bus.out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_diff", bus.diff, 8'h7F);
      check("bp_borrow", bus.borrow, 0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("bp_in_ready", bus.in_ready, 1);
    check("bp_out_valid_clr", bus.out_valid, 0);
    check("bp_diff_hold", bus.diff, 8'h7F);

    // Reset in the middle of RUN discards the partial result.
    bus.a        = 8'hAA;
    bus.b        = 8'h55;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_in_ready", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mr_out_valid", bus.out_valid, 0);
    check("mr_diff", bus.diff, 0);
    check("mr_borrow", bus.borrow, 0);
    check("mr_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h10, 8'h20, 8'hF0, 1'b1);

    // Back-to-back random pairs with random out_ready.
    n_acc = 0;
    n_hs  = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      bus.a         = ra;
      bus.b         = rb;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.in_ready) begin
        n_acc++;
      end else begin
        check("rnd_in_ready", bus.in_ready, 1);
      end
      @(negedge clk);
      got_hs = 1'b0;
      wt     = 0;
      while (!got_hs && wt < 60) begin
        bus.a         = 8'($urandom);
        bus.b         = 8'($urandom);
        bus.out_ready = 1'($urandom_range(0, 1));
        if (bus.out_valid && bus.out_ready) begin
          got_hs = 1'b1;
          n_hs++;
          check("rnd_diff", bus.diff, 32'(8'(ra - rb)));
          check("rnd_borrow", bus.borrow, (ra < rb) ? 1 : 0);
        end
        @(negedge clk);
        wt++;
      end
      if (!got_hs) check("rnd_timeout", 0, 1);
      bus.in_valid = 1'b0;
    end
    check("rnd_accepted", n_acc, 1000);
    check("rnd_handshakes", n_hs, n_acc);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor. Computes diff = a - b and borrow-out, LSB-first, one bit per clock.
- Built around a single full_subtractor cell, which is the subtract-direction counterpart of the adder cells.
- Valid/ready handshake on both the operand side and the result side.
- Forms the serial arithmetic path of the small CPU datapath. It trades latency for a single 1-bit cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range >= 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a/b are presented
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  WIDTH  minuend, unsigned
- b  in  WIDTH  subtrahend, unsigned
- out_valid  out  1  diff/borrow hold a finished result
- out_ready  in  1  consumer accepts result
- diff  out  WIDTH  (a - b) mod 2^WIDTH
- borrow  out  1  1 iff a < b (unsigned)

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, all internal shift/count registers=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a into sh_a and b into sh_b. Set brw=0 and cnt=0. Go to RUN.
  - RUN: in_ready=0. Each cycle, feed sh_a[0], sh_b[0], brw into full_subtractor:
    - d = x^y^bin; bout = (~x&y) | (~(x^y)&bin).
    - Shift sh_a and sh_b right by 1.
    - Shift d into the MSB of sh_d (right shift).
    - brw <= bout; cnt <= cnt+1.
    - When cnt==WIDTH-1 in the current cycle: load diff <= final sh_d value, borrow <= final bout, then go to DONE.
  - DONE: out_valid=1; diff/borrow held stable. On out_valid&&out_ready, clear out_valid and go to IDLE. diff/borrow keep their last value until the next result loads.
- Latency:
  - Operand handshake in cycle T gives out_valid=1 in cycle T+WIDTH+1.
  - Throughput: one result per WIDTH+2 cycles with out_ready tied high.
- in_ready is registered-state decoded; it is 0 in RUN and DONE. in_valid in those states is ignored; operands are not captured.
- No overlap: a new operand handshake is earliest the cycle after the result handshake (state is IDLE then).
- out_ready held low: remain in DONE indefinitely, no change to outputs.
- cnt width = $clog2(WIDTH); no wrap beyond WIDTH-1 because the RUN exit occurs at WIDTH-1.
- Reset asserted mid-RUN or in DONE: immediately return to the reset values; the partial result is discarded.
- a==b yields diff=0, borrow=0. Result equals a + ~b + 1 with borrow = ~carry_out (bench reference model).

Decomposition:
- Shared package (sub_pkg):
  - state typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE}.
  - Default WIDTH constant.
- Sub-module full_subtractor (x, y, bin -> d, bout), purely combinational.
  - May itself be two half_subtractor instances plus an OR.
  - Gets its own exhaustive 8-row bench.
- Top holds the FSM, shift registers, counter and output registers.

Test Plan (WIDTH=8, out_ready=1 unless stated):
- Reset, then a=0x05, b=0x03 accepted at T -> out_valid at T+9, diff=0x02, borrow=0; in_ready=0 during T+1..T+9.
- a=0x03, b=0x05 -> diff=0xFE, borrow=1. a=0x00, b=0x01 -> diff=0xFF, borrow=1.
- a=0xFF, b=0xFF -> diff=0x00, borrow=0. a=0xFF, b=0x00 -> diff=0xFF, borrow=0.
- Backpressure: a=0x80, b=0x01, out_ready low 5 cycles after out_valid -> diff=0x7F, borrow=0 stable all 5 cycles. in_valid=1 with a=0x11 during RUN/DONE is not captured. After the out_ready handshake, in_ready=1 next cycle.
- rst_n pulsed low 4 cycles into RUN (a=0xAA, b=0x55) -> out_valid=0, diff=0, borrow=0, in_ready=1 immediately. Next op a=0x10, b=0x20 -> diff=0xF0, borrow=1.
- Random 1000 pairs, back-to-back, random out_ready -> each result matches (a-b)&0xFF and a<b; exactly one out_valid handshake per accepted operand pair.
